// File: rtl/boot_clock_pkg.sv
// boot_clock_gen shared types and helpers.
// Per-channel state is stored at MAX_DIV_W and zero-extended from DIV_WIDTH.
package boot_clock_pkg;

  localparam int MAX_CH    = 8;
  localparam int MAX_DIV_W = 16;

  typedef logic [MAX_DIV_W-1:0] div_t;

  localparam div_t MIN_DIV = div_t'(2);

  typedef struct packed {
    div_t cnt;
    div_t div;
    div_t pending;
    logic pend_valid;
    logic run;
  } ch_state_t;

  function automatic div_t eff_div(div_t d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/boot_clock_gen_if.sv
// boot_clock_gen divide-ratio load bus.
// Master drives a one-cycle DIV_LOAD strobe with target channel and ratio.
interface boot_clock_gen_if #(
  parameter int NUM_CH    = 2,
  parameter int DIV_WIDTH = 8
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 DIV_LOAD;
  logic [CH_W-1:0]      DIV_CH;
  logic [DIV_WIDTH-1:0] DIV_VAL;

  modport master (
    output DIV_LOAD,
    output DIV_CH,
    output DIV_VAL
  );

  modport slave (
    input DIV_LOAD,
    input DIV_CH,
    input DIV_VAL
  );

endinterface

// File: rtl/boot_clock_div_ch.sv
// boot_clock_gen single channel: programmable divider with
// wrap-aligned stop and deferred ratio update.
module boot_clock_div_ch
  import boot_clock_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 ld,
  input  logic [DIV_WIDTH-1:0] ld_val,
  output logic                 o,
  output logic                 tick,
  output logic                 active
);

  ch_state_t st_q, st_d;
  logic      o_q, o_d;
  logic      tick_q, tick_d;

  div_t n;
  div_t h;
  div_t cnt_inc;
  div_t val;
  div_t nxt_div;
  logic at_end;
  logic is_idle;
  logic is_wrap;
  logic is_run;

  always_comb begin
    val     = div_t'(ld_val);
    n       = eff_div(st_q.div);
    h       = n >> 1;
    cnt_inc = st_q.cnt + div_t'(1);
    at_end  = (st_q.cnt == (n - div_t'(1)));
    is_idle = !st_q.run;
    is_wrap = st_q.run && at_end;
    is_run  = st_q.run && !at_end;
    // A load on the wrap edge beats an older pending value
    nxt_div = st_q.pend_valid ? st_q.pending : st_q.div;
    if (ld) begin
      nxt_div = val;
    end
  end

  always_comb begin
    st_d   = st_q;
    o_d    = o_q;
    tick_d = 1'b0;
    unique case (1'b1)
      is_idle: begin
        o_d = 1'b0;
        if (ld) begin
          st_d.div = val;
        end
        if (en) begin
          st_d.cnt = '0;
          st_d.run = 1'b1;
          o_d      = 1'b1;
          tick_d   = 1'b1;
        end
      end
      is_wrap: begin
        st_d.div        = nxt_div;
        st_d.pend_valid = 1'b0;
        st_d.cnt        = '0;
        if (en) begin
          o_d    = 1'b1;
          tick_d = 1'b1;
        end else begin
          o_d      = 1'b0;
          st_d.run = 1'b0;
        end
      end
      is_run: begin
        st_d.cnt = cnt_inc;
        o_d      = (cnt_inc < h);
        if (ld) begin
          st_d.pending    = val;
          st_d.pend_valid = 1'b1;
        end
      end
      default: begin
        st_d = st_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q.cnt        <= '0;
      st_q.div        <= div_t'(DEFAULT_DIV);
      st_q.pending    <= '0;
      st_q.pend_valid <= 1'b0;
      st_q.run        <= 1'b0;
      o_q             <= 1'b0;
      tick_q          <= 1'b0;
    end else begin
      st_q   <= st_d;
      o_q    <= o_d;
      tick_q <= tick_d;
    end
  end

  assign o      = o_q;
  assign tick   = tick_q;
  assign active = st_q.run;

endmodule

// File: rtl/boot_clock_gen.sv
// boot_clock_gen top: decodes the load bus into per-channel strobes
// and instantiates one divider per channel.
module boot_clock_gen
  import boot_clock_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] EN,
  boot_clock_gen_if.slave   cfg,
  output logic [NUM_CH-1:0] O,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] ACTIVE
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ld;

  // Out-of-range channel numbers match no strobe and are dropped
  always_comb begin
    ld = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.DIV_LOAD && (cfg.DIV_CH == CH_W'(i))) begin
        ld[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    boot_clock_div_ch #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk    (CLK),
      .rst_n  (RST_N),
      .en     (EN[g]),
      .ld     (ld[g]),
      .ld_val (cfg.DIV_VAL),
      .o      (O[g]),
      .tick   (TICK[g]),
      .active (ACTIVE[g])
    );
  end

endmodule

// File: tb/tb_boot_clock_gen.sv
// boot_clock_gen bench: directed vector table plus random stimulus
// against an elapsed-time reference model.
module tb_boot_clock_gen;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int DEF = 4;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [NCH-1:0] EN;
  logic [NCH-1:0] O;
  logic [NCH-1:0] TICK;
  logic [NCH-1:0] ACTIVE;

  boot_clock_gen_if #(.NUM_CH(NCH), .DIV_WIDTH(DW)) cfg();

  boot_clock_gen #(
    .NUM_CH      (NCH),
    .DIV_WIDTH   (DW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .EN     (EN),
    .cfg    (cfg),
    .O      (O),
    .TICK   (TICK),
    .ACTIVE (ACTIVE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit       rst_n;
    bit [2:0] en;
    bit       ld;
    bit [1:0] ch;
    bit [7:0] val;
    int       cc;
    bit       o;
    bit       t;
    bit       a;
  } vec_t;

  vec_t vecs[$];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  // Reference model: period start edge and ratio per channel
  bit m_run[NCH];
  int m_n[NCH];
  int m_start[NCH];
  bit m_pv[NCH];
  int m_pn[NCH];
  bit m_o[NCH];
  bit m_t[NCH];

  function automatic int clampn(int v);
    return (v < 2) ? 2 : v;
  endfunction

  function void add(bit r, bit [2:0] e, bit l, bit [1:0] ch, bit [7:0] v,
                    int cc, bit o, bit t, bit a);
    vec_t x;
    x.rst_n = r; x.en = e; x.ld = l; x.ch = ch; x.val = v;
    x.cc = cc; x.o = o; x.t = t; x.a = a;
    vecs.push_back(x);
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
  endtask

  task automatic model_edge(bit r, bit [2:0] e, bit l, bit [1:0] ch, bit [7:0] v);
    for (int c = 0; c < NCH; c++) begin
      bit ldc;
      int el;
      ldc = l && (int'(ch) == c);
      if (!r) begin
        m_run[c] = 0; m_n[c] = clampn(DEF); m_pv[c] = 0;
        m_o[c] = 0; m_t[c] = 0;
      end else if (!m_run[c]) begin
        if (ldc) m_n[c] = clampn(int'(v));
        m_o[c] = 0; m_t[c] = 0;
        if (e[c]) begin
          m_run[c] = 1; m_start[c] = cyc; m_o[c] = 1; m_t[c] = 1;
        end
      end else begin
        el = cyc - m_start[c];
        if (el == m_n[c]) begin
          if (ldc) m_n[c] = clampn(int'(v));
          else if (m_pv[c]) m_n[c] = m_pn[c];
          m_pv[c] = 0;
          if (e[c]) begin
            m_start[c] = cyc; m_o[c] = 1; m_t[c] = 1;
          end else begin
            m_run[c] = 0; m_o[c] = 0; m_t[c] = 0;
          end
        end else begin
          m_o[c] = (el < m_n[c] / 2);
          m_t[c] = 0;
          if (ldc) begin
            m_pv[c] = 1; m_pn[c] = clampn(int'(v));
          end
        end
      end
    end
  endtask

  task automatic step(bit r, bit [2:0] e, bit l, bit [1:0] ch, bit [7:0] v);
    RST_N        = r;
    EN           = e;
    cfg.DIV_LOAD = l;
    cfg.DIV_CH   = ch;
    cfg.DIV_VAL  = v;
    cyc++;
    model_edge(r, e, l, ch, v);
    @(posedge CLK);
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("model O[%0d]", c), int'(O[c]), int'(m_o[c]));
      chk($sformatf("model TICK[%0d]", c), int'(TICK[c]), int'(m_t[c]));
      chk($sformatf("model ACTIVE[%0d]", c), int'(ACTIVE[c]), int'(m_run[c]));
    end
  endtask

  bit [2:0] re;
  bit       rr;
  bit       rl;
  bit [1:0] rch;
  bit [7:0] rv;

  initial begin
    RST_N = 1'b0; EN = '0;
    cfg.DIV_LOAD = 1'b0; cfg.DIV_CH = '0; cfg.DIV_VAL = '0;

    // reset, default N=4 on ch0
    add(0,3'b000,0,0,0, 0, 0,0,0);
    add(1,3'b000,0,0,0, 0, 0,0,0);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    add(1,3'b001,0,0,0, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    add(1,3'b001,0,0,0, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    // ch1 N=5 loaded while idle, then N=0 -> period 2, then stop
    add(1,3'b011,1,1,5, 1, 1,1,1);
    add(1,3'b011,0,0,0, 1, 1,0,1);
    add(1,3'b011,0,0,0, 1, 0,0,1);
    add(1,3'b011,0,0,0, 1, 0,0,1);
    add(1,3'b011,0,0,0, 1, 0,0,1);
    add(1,3'b011,0,0,0, 1, 1,1,1);
    add(1,3'b011,1,1,0, 1, 1,0,1);
    add(1,3'b011,0,0,0, 1, 0,0,1);
    add(1,3'b011,0,0,0, 1, 0,0,1);
    add(1,3'b011,0,0,0, 1, 0,0,1);
    add(1,3'b011,0,0,0, 1, 1,1,1);
    add(1,3'b011,0,0,0, 1, 0,0,1);
    add(1,3'b011,0,0,0, 1, 1,1,1);
    add(1,3'b011,0,0,0, 1, 0,0,1);
    add(1,3'b001,0,0,0, 1, 0,0,0);
    add(1,3'b001,0,0,0, 1, 0,0,0);
    // ch0 load 6 mid-period, then load 4 on the wrap edge
    add(1,3'b001,0,0,0, 0, 1,1,1);
    add(1,3'b001,1,0,6, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    add(1,3'b001,0,0,0, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    add(1,3'b001,0,0,0, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,1,0,4, 0, 1,1,1);
    add(1,3'b001,0,0,0, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    // ch2 N=8, EN dropped at cnt=1
    add(1,3'b101,1,2,8, 2, 1,1,1);
    add(1,3'b001,0,0,0, 2, 1,0,1);
    add(1,3'b001,0,0,0, 2, 1,0,1);
    add(1,3'b001,0,0,0, 2, 1,0,1);
    add(1,3'b001,0,0,0, 2, 0,0,1);
    add(1,3'b001,0,0,0, 2, 0,0,1);
    add(1,3'b001,0,0,0, 2, 0,0,1);
    add(1,3'b001,0,0,0, 2, 0,0,1);
    add(1,3'b001,0,0,0, 2, 0,0,0);
    add(1,3'b001,0,0,0, 2, 0,0,0);
    // ch0 gets N=6 then reset mid-high: div back to 4
    add(1,3'b001,1,0,6, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    add(0,3'b001,0,0,0, 0, 0,0,0);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    add(1,3'b001,0,0,0, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    // out-of-range channel ignored; loads 3 then 7: 7 wins
    add(1,3'b001,1,3,2, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    add(1,3'b001,1,0,3, 0, 1,0,1);
    add(1,3'b001,1,0,7, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    add(1,3'b001,0,0,0, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 1,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 0,0,1);
    add(1,3'b001,0,0,0, 0, 1,1,1);
    // ch2 EN dropped and reasserted before wrap keeps running
    add(1,3'b101,0,0,0, 2, 1,1,1);
    add(1,3'b001,0,0,0, 2, 1,0,1);
    add(1,3'b101,0,0,0, 2, 0,0,1);
    add(1,3'b101,0,0,0, 2, 0,0,1);
    add(1,3'b101,0,0,0, 2, 1,1,1);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].ld, vecs[i].ch, vecs[i].val);
      chk($sformatf("vec%0d O[%0d]", i, vecs[i].cc),
          int'(O[vecs[i].cc]), int'(vecs[i].o));
      chk($sformatf("vec%0d TICK[%0d]", i, vecs[i].cc),
          int'(TICK[vecs[i].cc]), int'(vecs[i].t));
      chk($sformatf("vec%0d ACTIVE[%0d]", i, vecs[i].cc),
          int'(ACTIVE[vecs[i].cc]), int'(vecs[i].a));
    end

    re = 3'b101;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 15) == 0) re[c] = ~re[c];
      rr  = ($urandom_range(0, 299) != 0);
      rl  = ($urandom_range(0, 5) == 0);
      rch = 2'($urandom_range(0, 3));
      rv  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      step(rr, re, rl, rch, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
